// File: rtl/audio_pkg.sv
// Shared constants and types for the I2S audio output path.
package audio_pkg;

    localparam int SAMPLE_W       = 16;
    localparam int I2S_SLOT_BITS  = 32;
    localparam int I2S_FRAME_BITS = 64;
    localparam int BCLK_HALF_DEF  = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO: registered level/full/empty, head entry always visible on dout.
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    import audio_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        level_d = level_q + LVL_W'(push) - LVL_W'(pop);
        full_d  = (level_d == LVL_W'(DEPTH));
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign level = level_q;

endmodule

// File: rtl/audio_i2s_serializer.sv
// Mono I2S master: FIFO-buffered samples sent on both slots, BCLK/LRCK generated locally.
module audio_i2s_serializer #(
    parameter int BCLK_HALF  = audio_pkg::BCLK_HALF_DEF,
    parameter int SAMPLE_W   = audio_pkg::SAMPLE_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic signed [SAMPLE_W-1:0]    sample,
    input  logic                          wr,
    output logic                          dac_bclk,
    output logic                          dac_lrck,
    output logic                          dac_dat,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic                          overflow
);
    import audio_pkg::*;

    localparam int BIT_W = $clog2(I2S_FRAME_BITS);
    localparam int POS_W = $clog2(I2S_SLOT_BITS);
    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int SEL_W = $clog2(SAMPLE_W);

    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                bclk_q, bclk_d;
    logic                lrck_q, lrck_d;
    logic                dat_q, dat_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_W-1:0] cur_sample_q, cur_sample_d;

    logic                div_tc;
    logic                fall_evt;
    logic [BIT_W-1:0]    bit_nxt;
    logic [POS_W-1:0]    slot_pos;
    logic [SEL_W-1:0]    sel;
    logic                frame_start;
    logic                push;
    logic                pop;
    logic                fifo_empty;
    logic [SAMPLE_W-1:0] fifo_head;

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (sample),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Fall event: the cycle in which BCLK is about to go 1->0.
    always_comb begin
        div_tc      = (div_cnt_q == DIV_W'(BCLK_HALF - 1));
        fall_evt    = div_tc && bclk_q;
        bit_nxt     = bit_cnt_q + BIT_W'(1);
        frame_start = fall_evt && (bit_nxt == '0);
        pop         = frame_start && !fifo_empty;
        push        = wr && (!fifo_full || pop);
    end

    always_comb begin
        div_cnt_d    = div_tc ? '0 : div_cnt_q + DIV_W'(1);
        bclk_d       = div_tc ? ~bclk_q : bclk_q;
        bit_cnt_d    = bit_cnt_q;
        lrck_d       = lrck_q;
        dat_d        = dat_q;
        cur_sample_d = pop ? fifo_head : cur_sample_q;
        slot_pos     = bit_nxt[POS_W-1:0];
        sel          = SEL_W'(SAMPLE_W - int'(slot_pos));
        // MSB lands one BCLK after the LRCK edge; slot position 0 and the tail are padding.
        if (fall_evt) begin
            bit_cnt_d = bit_nxt;
            lrck_d    = bit_nxt[BIT_W-1];
            dat_d     = (slot_pos != '0 && int'(slot_pos) <= SAMPLE_W) ?
                        cur_sample_q[sel] : 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt_q    <= '0;
            bclk_q       <= 1'b0;
            lrck_q       <= 1'b0;
            dat_q        <= 1'b0;
            bit_cnt_q    <= '1;
            cur_sample_q <= '0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            bclk_q       <= bclk_d;
            lrck_q       <= lrck_d;
            dat_q        <= dat_d;
            bit_cnt_q    <= bit_cnt_d;
            cur_sample_q <= cur_sample_d;
        end
    end

    assign dac_bclk = bclk_q;
    assign dac_lrck = lrck_q;
    assign dac_dat  = dat_q;
    assign underrun = frame_start && fifo_empty;
    assign overflow = wr && fifo_full && !pop;

endmodule

// File: tb/tb_audio_i2s_serializer.sv
// Directed bench: decodes I2S frames from the pins and compares them with hand-computed words.
module tb_audio_i2s_serializer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wr    = 1'b0;
    logic [15:0] sample = 16'h0;
    logic        dac_bclk, dac_lrck, dac_dat, fifo_full, underrun, overflow;
    logic [2:0]  fifo_level;

    always #5 clock = ~clock;

    audio_i2s_serializer dut (
        .clock      (clock),
        .reset      (reset),
        .sample     (sample),
        .wr         (wr),
        .dac_bclk   (dac_bclk),
        .dac_lrck   (dac_lrck),
        .dac_dat    (dac_dat),
        .fifo_full  (fifo_full),
        .fifo_level (fifo_level),
        .underrun   (underrun),
        .overflow   (overflow)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pin monitor: b_tb tracks the frame bit on each observed BCLK fall.
    int          cyc = 0, b_tb = 63, frames_done = 0, ucnt = 0, lrck_err = 0;
    int          last_bclk_rise = -1, bclk_period = 0;
    int          last_lrck_rise = -1, lrck_period = 0, lrck_high = 0;
    logic        prev_bclk = 1'b0, prev_lrck = 1'b0;
    logic [63:0] cur_bits = '0;
    logic [63:0] frame_bits [64];
    logic [63:0] pad_mask;

    initial forever begin
        @(negedge clock);
        cyc++;
        if (reset) begin
            b_tb = 63; prev_bclk = 1'b0; prev_lrck = 1'b0; cur_bits = '0;
            last_bclk_rise = -1; last_lrck_rise = -1;
        end else begin
            if (underrun) ucnt++;
            if (dac_bclk && !prev_bclk) begin
                if (last_bclk_rise >= 0) bclk_period = cyc - last_bclk_rise;
                last_bclk_rise = cyc;
            end
            if (dac_lrck && !prev_lrck) begin
                if (last_lrck_rise >= 0) lrck_period = cyc - last_lrck_rise;
                last_lrck_rise = cyc;
            end
            if (!dac_lrck && prev_lrck && last_lrck_rise >= 0) lrck_high = cyc - last_lrck_rise;
            if (!dac_bclk && prev_bclk) begin
                b_tb = (b_tb + 1) % 64;
                if (b_tb == 0) cur_bits = '0;
                cur_bits[b_tb] = dac_dat;
                if (dac_lrck !== (b_tb >= 32)) lrck_err++;
                if (b_tb == 63) begin
                    if (frames_done < 64) frame_bits[frames_done] = cur_bits;
                    frames_done++;
                end
            end
            prev_bclk = dac_bclk;
            prev_lrck = dac_lrck;
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_frames(input int n, input string tag);
        int t = 0;
        while (frames_done < n && t < 8000) begin tick(); t++; end
        chk({tag, "_timeout"}, 64'(frames_done >= n), 64'd1);
    endtask

    function automatic logic [15:0] slot_word(input logic [63:0] fb, input int base);
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[15-i] = fb[base+1+i];
        return w;
    endfunction

    task automatic check_frame(input string tag, input int idx, input logic [15:0] exp);
        chk({tag, "_left"},  64'(slot_word(frame_bits[idx], 0)),  64'(exp));
        chk({tag, "_right"}, 64'(slot_word(frame_bits[idx], 32)), 64'(exp));
        chk({tag, "_pad"},   frame_bits[idx] & pad_mask, 64'd0);
    endtask

    initial begin
        int t;
        for (int i = 0; i < 64; i++) begin
            pad_mask[i] = !((i >= 1 && i <= 16) || (i >= 33 && i <= 48));
            frame_bits[i] = '0;
        end

        // Reset state
        repeat (4) tick();
        chk("rst_bclk", 64'(dac_bclk), 64'd0);
        chk("rst_lrck", 64'(dac_lrck), 64'd0);
        chk("rst_dat", 64'(dac_dat), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_full", 64'(fifo_full), 64'd0);
        chk("rst_underrun", 64'(underrun), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        reset = 1'b0;

        // Idle: frames 0 and 1, nothing written
        wait_frames(2, "idle");
        chk("bclk_period", 64'(bclk_period), 64'd16);
        chk("lrck_period", 64'(lrck_period), 64'd1024);
        chk("lrck_high", 64'(lrck_high), 64'd512);
        chk("idle_frame0", frame_bits[0], 64'd0);
        chk("idle_frame1", frame_bits[1], 64'd0);
        chk("idle_underruns", 64'(ucnt), 64'd2);

        // Single sample into empty FIFO, serialised in frame 2
        wr = 1'b1; sample = 16'hA5C3;
        tick();
        wr = 1'b0;
        chk("a5c3_level1", 64'(fifo_level), 64'd1);
        wait_frames(3, "a5c3");
        check_frame("a5c3", 2, 16'hA5C3);
        chk("a5c3_level0", 64'(fifo_level), 64'd0);
        chk("a5c3_no_underrun", 64'(ucnt), 64'd2);

        // Burst of five: fifth write overflows
        for (int i = 1; i <= 5; i++) begin
            wr = 1'b1; sample = 16'(i);
            #1;
            chk($sformatf("burst_ovf%0d", i), 64'(overflow), 64'(i == 5));
            tick();
        end
        wr = 1'b0;
        chk("burst_level", 64'(fifo_level), 64'd4);
        chk("burst_full", 64'(fifo_full), 64'd1);
        wait_frames(7, "burst");
        for (int i = 0; i < 4; i++) check_frame($sformatf("burst_f%0d", i + 1), 3 + i, 16'(i + 1));
        chk("burst_underruns", 64'(ucnt), 64'd2);

        // Full FIFO, write lands on the frame-start pop cycle (16 cycles after the last bit-63 fall)
        for (int i = 1; i <= 4; i++) begin
            wr = 1'b1; sample = 16'(i * 16'h0011);
            tick();
        end
        wr = 1'b0;
        repeat (11) tick();
        wr = 1'b1; sample = 16'h0055;
        #1;
        chk("pop_push_ovf", 64'(overflow), 64'd0);
        chk("pop_push_full", 64'(fifo_full), 64'd1);
        tick();
        wr = 1'b0;
        chk("pop_push_level", 64'(fifo_level), 64'd4);
        wait_frames(12, "pop_push");
        for (int i = 0; i < 5; i++) check_frame($sformatf("pp_f%0d", i), 7 + i, 16'((i + 1) * 16'h0011));
        chk("pop_push_underruns", 64'(ucnt), 64'd2);

        // Hold: frame 12 repeats 0055, then 8000 twice
        repeat (20) tick();
        chk("hold_underrun12", 64'(ucnt), 64'd3);
        wr = 1'b1; sample = 16'h8000;
        tick();
        wr = 1'b0;
        wait_frames(14, "hold_a");
        check_frame("hold_f12", 12, 16'h0055);
        check_frame("hold_f13", 13, 16'h8000);
        chk("hold_no_underrun13", 64'(ucnt), 64'd3);
        wait_frames(15, "hold_b");
        check_frame("hold_f14", 14, 16'h8000);
        chk("hold_underrun14", 64'(ucnt), 64'd4);

        // Reset mid-frame with three entries queued
        repeat (20) tick();
        for (int i = 1; i <= 3; i++) begin
            wr = 1'b1; sample = 16'(i * 16'h1111);
            tick();
        end
        wr = 1'b0;
        chk("mid_level3", 64'(fifo_level), 64'd3);
        t = 0;
        while (b_tb != 40 && t < 3000) begin tick(); t++; end
        chk("mid_b40_timeout", 64'(b_tb == 40), 64'd1);
        chk("mid_lrck_pre", 64'(dac_lrck), 64'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_bclk", 64'(dac_bclk), 64'd0);
        chk("mid_rst_lrck", 64'(dac_lrck), 64'd0);
        chk("mid_rst_dat", 64'(dac_dat), 64'd0);
        chk("mid_rst_level", 64'(fifo_level), 64'd0);
        chk("mid_rst_full", 64'(fifo_full), 64'd0);
        tick();
        reset = 1'b0;
        wait_frames(17, "post_rst");
        chk("post_rst_f0", frame_bits[15], 64'd0);
        chk("post_rst_f1", frame_bits[16], 64'd0);
        chk("lrck_align", 64'(lrck_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
